// File: rtl/alarm_trigger_if.sv
// Signal bundle between the alarm trigger and its time, puzzle and output peers.
interface alarm_trigger_if;
    logic [13:0] alarm_time;
    logic [13:0] cur_time;
    logic        minute_tick;
    logic        alarm_en;
    logic        snooze;
    logic        puzzle_solved;
    logic        ringing;
    logic        buzzer;
    logic        snoozing;
    logic        dismissed;
    logic        missed;

    modport master (
        output alarm_time, cur_time, minute_tick, alarm_en, snooze, puzzle_solved,
        input  ringing, buzzer, snoozing, dismissed, missed
    );

    modport slave (
        input  alarm_time, cur_time, minute_tick, alarm_en, snooze, puzzle_solved,
        output ringing, buzzer, snoozing, dismissed, missed
    );
endinterface

// File: rtl/alarm_trigger.sv
// Alarm ring/snooze/timeout controller: rings on a rising time match,
// drives a square-wave buzzer, and supports snooze, auto-timeout and puzzle dismissal.
module alarm_trigger #(
    parameter int TONE_DIV         = 50000,
    parameter int SNOOZE_MIN       = 5,
    parameter int RING_TIMEOUT_MIN = 10,
    parameter int MAX_SNOOZES      = 3
) (
    input logic            clk,
    input logic            rst,
    alarm_trigger_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RINGING, SNOOZE} state_t;

    state_t      state, state_nxt;
    logic        match, match_q, trigger;
    logic [3:0]  ring_cnt, ring_nxt;
    logic [3:0]  snz_cnt, snz_nxt;
    logic [2:0]  used, used_nxt;
    logic [15:0] tone, tone_nxt;
    logic        buzz, buzz_nxt;
    logic        dism, dism_nxt;
    logic        miss, miss_nxt;

    assign match   = (bus.cur_time == bus.alarm_time);
    assign trigger = match & ~match_q & bus.alarm_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            match_q  <= 1'b1;
            ring_cnt <= '0;
            snz_cnt  <= '0;
            used     <= '0;
            tone     <= '0;
            buzz     <= 1'b0;
            dism     <= 1'b0;
            miss     <= 1'b0;
        end else begin
            state    <= state_nxt;
            match_q  <= match;
            ring_cnt <= ring_nxt;
            snz_cnt  <= snz_nxt;
            used     <= used_nxt;
            tone     <= tone_nxt;
            buzz     <= buzz_nxt;
            dism     <= dism_nxt;
            miss     <= miss_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ring_nxt  = ring_cnt;
        snz_nxt   = snz_cnt;
        used_nxt  = used;
        tone_nxt  = tone;
        buzz_nxt  = 1'b0;
        dism_nxt  = 1'b0;
        miss_nxt  = miss;
        case (state)
            IDLE: begin
                if (trigger) begin
                    state_nxt = RINGING;
                    ring_nxt  = '0;
                    used_nxt  = '0;
                    miss_nxt  = 1'b0;
                    tone_nxt  = '0;
                end
            end
            RINGING: begin
                if (!bus.alarm_en) begin
                    state_nxt = IDLE;
                end else if (bus.puzzle_solved) begin
                    state_nxt = IDLE;
                    dism_nxt  = 1'b1;
                end else if (bus.snooze && used < 3'(MAX_SNOOZES)) begin
                    state_nxt = SNOOZE;
                    snz_nxt   = 4'(SNOOZE_MIN);
                    used_nxt  = used + 3'd1;
                end else if (bus.minute_tick &&
                             ring_cnt == 4'(RING_TIMEOUT_MIN - 1)) begin
                    state_nxt = IDLE;
                    miss_nxt  = 1'b1;
                end else begin
                    if (bus.minute_tick) ring_nxt = ring_cnt + 4'd1;
                    // Tone keeps running while we stay in RINGING
                    if (tone == 16'(TONE_DIV - 1)) begin
                        tone_nxt = '0;
                        buzz_nxt = ~buzz;
                    end else begin
                        tone_nxt = tone + 16'd1;
                        buzz_nxt = buzz;
                    end
                end
            end
            SNOOZE: begin
                if (!bus.alarm_en) begin
                    state_nxt = IDLE;
                end else if (bus.minute_tick) begin
                    if (snz_cnt == 4'd1) begin
                        state_nxt = RINGING;
                        ring_nxt  = '0;
                        tone_nxt  = '0;
                    end else begin
                        snz_nxt = snz_cnt - 4'd1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.ringing   = (state == RINGING);
    assign bus.snoozing  = (state == SNOOZE);
    assign bus.buzzer    = buzz;
    assign bus.dismissed = dism;
    assign bus.missed    = miss;
endmodule

// File: tb/tb_alarm_trigger.sv
// Scoreboard bench for alarm_trigger: directed scenarios then random
// stimulus, compared each cycle against a minute/cycle-level reference model.
module tb_alarm_trigger;
    localparam int TD = 8;
    localparam int SM = 5;
    localparam int RT = 10;
    localparam int MS = 3;
    localparam int M_IDLE = 0;
    localparam int M_RING = 1;
    localparam int M_SNZ  = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alarm_trigger_if bus ();

    alarm_trigger #(
        .TONE_DIV(TD), .SNOOZE_MIN(SM),
        .RING_TIMEOUT_MIN(RT), .MAX_SNOOZES(MS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    logic [13:0] g_at, g_ct;
    logic        g_en;

    int mode, rmin, snz_left, snoozes, rcyc;
    bit prev, m_missed, m_dism;

    logic [4:0] exp_q[$];
    int tests = 0;
    int fails = 0;

    task automatic model_step(input bit r, input bit tk, input bit sz, input bit pz);
        bit mt, trig;
        int was;
        if (r) begin
            mode = M_IDLE; prev = 1'b1; rmin = 0; snz_left = 0;
            snoozes = 0; rcyc = 0; m_missed = 1'b0; m_dism = 1'b0;
            return;
        end
        mt   = (g_ct == g_at);
        trig = mt && !prev && g_en;
        prev = mt;
        m_dism = 1'b0;
        was = mode;
        case (mode)
            M_IDLE: if (trig) begin
                mode = M_RING; rmin = 0; snoozes = 0; m_missed = 1'b0;
            end
            M_RING: begin
                if (!g_en) mode = M_IDLE;
                else if (pz) begin mode = M_IDLE; m_dism = 1'b1; end
                else if (sz && snoozes < MS) begin
                    mode = M_SNZ; snz_left = SM; snoozes++;
                end else if (tk) begin
                    if (rmin + 1 == RT) begin mode = M_IDLE; m_missed = 1'b1; end
                    else rmin++;
                end
            end
            default: begin
                if (!g_en) mode = M_IDLE;
                else if (tk) begin
                    if (snz_left == 1) begin mode = M_RING; rmin = 0; end
                    else snz_left--;
                end
            end
        endcase
        if (mode == M_RING) rcyc = (was == M_RING) ? rcyc + 1 : 0;
    endtask

    task automatic apply(input bit r, input bit tk, input bit sz, input bit pz);
        bit b;
        @(negedge clk);
        rst = r;
        bus.alarm_time = g_at;
        bus.cur_time = g_ct;
        bus.alarm_en = g_en;
        bus.minute_tick = tk;
        bus.snooze = sz;
        bus.puzzle_solved = pz;
        model_step(r, tk, sz, pz);
        b = (mode == M_RING) && (((rcyc / TD) % 2) == 1);
        exp_q.push_back({mode == M_RING, b, mode == M_SNZ, m_dism, m_missed});
    endtask

    task automatic idle(input int n);
        repeat (n) apply(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic ticks(input int n, input int gap);
        repeat (n) begin
            apply(1'b0, 1'b1, 1'b0, 1'b0);
            idle(gap);
        end
    endtask

    task automatic retrigger();
        g_ct = 14'h0731; idle(2);
        g_ct = 14'h0730; idle(3);
    endtask

    // Monitor: one comparison per clock once an expectation is pending
    initial begin
        logic [4:0] e, a;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {bus.ringing, bus.buzzer, bus.snoozing, bus.dismissed, bus.missed};
                tests++;
                if (a !== e)begin
                    fails++;
                    $display("FAIL outputs t=%0t got=%b want=%b (ring,buz,snz,dis,mis)",
                             $time, a, e);
                end
            end
        end
    end

    initial begin
        int guard;
        g_at = 14'h0730; g_ct = 14'h0729; g_en = 1'b1;
        bus.alarm_time = g_at; bus.cur_time = g_ct; bus.alarm_en = g_en;
        bus.minute_tick = 1'b0; bus.snooze = 1'b0; bus.puzzle_solved = 1'b0;

        apply(1'b1, 1'b0, 1'b0, 1'b0);
        apply(1'b1, 1'b0, 1'b0, 1'b0);
        idle(3);
        g_ct = 14'h0730; idle(40);
        apply(1'b0, 1'b0, 1'b0, 1'b1);
        idle(200);

        retrigger();
        repeat (3) begin
            apply(1'b0, 1'b0, 1'b1, 1'b0);
            idle(2);
            ticks(4, 2);
            ticks(1, 2);
            idle(3);
        end
        apply(1'b0, 1'b0, 1'b1, 1'b0);
        idle(3);
        ticks(10, 2);
        idle(5);

        retrigger();
        ticks(9, 1);
        apply(1'b0, 1'b1, 1'b1, 1'b1);
        idle(5);

        retrigger();
        idle(10);
        apply(1'b1, 1'b0, 1'b0, 1'b0);
        idle(5);

        retrigger();
        apply(1'b0, 1'b0, 1'b1, 1'b0);
        idle(3);
        g_en = 1'b0; idle(3);
        g_en = 1'b1; idle(2);

        g_ct = 14'h1200; idle(3);
        g_at = 14'h1200; idle(5);
        apply(1'b0, 1'b0, 1'b0, 1'b1);
        idle(2);

        g_at = 14'h0730; g_ct = 14'h0729;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(7) == 0)
                case ($urandom_range(2))
                    0: g_ct = 14'h0729;
                    1: g_ct = 14'h0730;
                    default: g_ct = 14'h0731;
                endcase
            if ($urandom_range(63) == 0)
                g_at = ($urandom_range(1) == 0) ? 14'h0730 : 14'h0731;
            g_en = ($urandom_range(199) != 0);
            apply($urandom_range(799) == 0, $urandom_range(2) == 0,
                  $urandom_range(24) == 0, $urandom_range(149) == 0);
        end

        guard = 0;
        while (exp_q.size() > 0 && guard < 10) begin
            @(posedge clk);
            guard++;
        end
        #2;
        if (exp_q.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL drain pending=%0d want=0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
